pc_gen: RTL and testbench

// - Parametrised next-gen program-counter generator at the head of the IF stage.
// - Sources a PC per cycle to the IFetcher over a valid/ready handshake.
// - Priority redirects: flush > jump > branch. Every redirect is tagged with an epoch so later stages can drop stale fetches.
// - Programmable post-redirect bubble. Optional BTB next-PC prediction.

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_btb.sv | 59 +++++
 rtl/pc_gen.sv | 153 +++++++++++++++
 tb/tb_pc_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the IF-stage PC generator.
// Holds the FSM state encoding, the redirect-source encoding and default parameters.
package pc_gen_pkg;

    localparam int unsigned DEF_INST_BYTES = 4;
    localparam int unsigned DEF_RESET_PC   = 0;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_FLUSH  = 2'd1,
        RD_JUMP   = 2'd2,
        RD_BRANCH = 2'd3
    } redir_src_e;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup plus one write port.
// Ports: clk/rst (sync, active-high, clears valid bits), lookup_pc_i -> hit_o/hit_target_o,
// wr_en_i/wr_pc_i/wr_target_i write one entry on the rising edge.
module pc_btb #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INST_BYTES  = 4,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
    output logic                  hit_o,
    output logic [ADDR_WIDTH-1:0] hit_target_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_pc_i,
    input  logic [ADDR_WIDTH-1:0] wr_target_i
);

    localparam int unsigned OFF   = $clog2(INST_BYTES);
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - OFF;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = lookup_pc_i[IDX_W+OFF-1:OFF];
    assign rd_tag = lookup_pc_i[ADDR_WIDTH-1:IDX_W+OFF];
    assign wr_idx = wr_pc_i[IDX_W+OFF-1:OFF];
    assign wr_tag = wr_pc_i[ADDR_WIDTH-1:IDX_W+OFF];

    assign hit_o        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign hit_target_o = target_q[rd_idx];

    // Instruction-aligned byte-offset bits carry no index/tag information.
    logic unused_off;
    assign unused_off = ^{lookup_pc_i[OFF-1:0], wr_pc_i[OFF-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator at the head of IF: sequential fetch, prioritised redirects
// (flush > jump > branch) with epoch tagging and a programmable post-redirect bubble.
// Ports: clk, rst (sync, active-high); pc/pc_epoch/pc_valid/pc_ready handshake to the
// IFetcher; pc_pred_taken; flush_*, jump_*, br_* redirect inputs.
// Optional macro PC_BTB_EN adds a direct-mapped BTB (pc_btb) for next-PC prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned RESET_PC     = DEF_RESET_PC,
    parameter int unsigned INST_BYTES   = DEF_INST_BYTES,
    parameter int unsigned REDIRECT_BUB = 1,
    parameter int unsigned EPOCH_WIDTH  = 2,
    parameter int unsigned BTB_ENTRIES  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [EPOCH_WIDTH-1:0] pc_epoch,
    output logic                   pc_valid,
    input  logic                   pc_ready,
    output logic                   pc_pred_taken,
    input  logic                   flush_valid,
    input  logic [ADDR_WIDTH-1:0]  flush_pc,
    input  logic                   jump_valid,
    input  logic [ADDR_WIDTH-1:0]  jump_dest,
    input  logic                   br_valid,
    input  logic [ADDR_WIDTH-1:0]  br_pc,
    input  logic [ADDR_WIDTH-1:0]  br_offset
);

    pc_state_e              state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
    logic                   pred_q, pred_d;

    redir_src_e             src;
    logic [ADDR_WIDTH-1:0]  target;
    logic [ADDR_WIDTH-1:0]  seq_pc;
    logic [ADDR_WIDTH-1:0]  next_pc;
    logic                   btb_hit;
    logic [ADDR_WIDTH-1:0]  btb_target;

    assign seq_pc = pc_q + ADDR_WIDTH'(INST_BYTES);

    // Lower-priority requests in the same cycle are simply dropped.
    always_comb begin
        src    = RD_NONE;
        target = '0;
        if (flush_valid) begin
            src    = RD_FLUSH;
            target = flush_pc;
        end else if (jump_valid) begin
            src    = RD_JUMP;
            target = jump_dest;
        end else if (br_valid) begin
            src    = RD_BRANCH;
            target = br_pc + br_offset;
        end
    end

`ifdef PC_BTB_EN
    logic                  btb_we;
    logic [ADDR_WIDTH-1:0] btb_wr_pc;

    // Branches are indexed by their own address; jumps by the current pc.
    assign btb_we    = (src == RD_JUMP) || (src == RD_BRANCH);
    assign btb_wr_pc = (src == RD_BRANCH) ? br_pc : pc_q;

    pc_btb #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INST_BYTES  (INST_BYTES),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc_i  (pc_q),
        .hit_o        (btb_hit),
        .hit_target_o (btb_target),
        .wr_en_i      (btb_we),
        .wr_pc_i      (btb_wr_pc),
        .wr_target_i  (target)
    );
`else
    logic unused_btb;
    assign unused_btb = (BTB_ENTRIES != 0);
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
`endif

    assign next_pc = btb_hit ? btb_target : seq_pc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        pred_d  = pred_q;
        if (src != RD_NONE) begin
            pc_d    = target;
            epoch_d = epoch_q + EPOCH_WIDTH'(1);
            pred_d  = 1'b0;
            cnt_d   = 4'(REDIRECT_BUB);
            state_d = (REDIRECT_BUB == 0) ? ST_RUN : ST_BUBBLE;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (pc_ready) begin
                        pc_d   = next_pc;
                        pred_d = btb_hit;
                    end
                end
                ST_BUBBLE: begin
                    // Last bubble cycle is the one where the counter reads 1.
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
            pc_q    <= ADDR_WIDTH'(RESET_PC);
            epoch_q <= '0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            pred_q  <= pred_d;
        end
    end

    assign pc            = pc_q;
    assign pc_epoch      = epoch_q;
    assign pc_valid      = (state_q == ST_RUN);
    assign pc_pred_taken = pred_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: table of one-cycle vectors with expected post-edge outputs,
// plus a BTB sequence when built with PC_BTB_EN.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [1:0]  pc_epoch;
    logic        pc_valid;
    logic        pc_ready;
    logic        pc_pred_taken;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        jump_valid;
    logic [31:0] jump_dest;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [31:0] br_offset;

    int checks;
    int failures;

    pc_gen #(
        .ADDR_WIDTH   (32),
        .RESET_PC     (32'h1000),
        .INST_BYTES   (4),
        .REDIRECT_BUB (1),
        .EPOCH_WIDTH  (2),
        .BTB_ENTRIES  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pc_epoch      (pc_epoch),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .pc_pred_taken (pc_pred_taken),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc),
        .jump_valid    (jump_valid),
        .jump_dest     (jump_dest),
        .br_valid      (br_valid),
        .br_pc         (br_pc),
        .br_offset     (br_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        fv;
        logic [31:0] fpc;
        logic        jv;
        logic [31:0] jd;
        logic        bv;
        logic [31:0] bpc;
        logic [31:0] boff;
        logic [31:0] e_pc;
        logic [1:0]  e_ep;
        logic        e_val;
        logic        e_pred;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic r, input logic rdy,
        input logic fv, input logic [31:0] fpc,
        input logic jv, input logic [31:0] jd,
        input logic bv, input logic [31:0] bpc, input logic [31:0] boff,
        input logic [31:0] e_pc, input logic [1:0] e_ep,
        input logic e_val, input logic e_pred);
        vec_t v;
        v.rst = r; v.rdy = rdy;
        v.fv = fv; v.fpc = fpc;
        v.jv = jv; v.jd = jd;
        v.bv = bv; v.bpc = bpc; v.boff = boff;
        v.e_pc = e_pc; v.e_ep = e_ep;
        v.e_val = e_val; v.e_pred = e_pred;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy,
                         input logic fv, input logic [31:0] fpc,
                         input logic jv, input logic [31:0] jd,
                         input logic bv, input logic [31:0] bpc,
                         input logic [31:0] boff);
        rst = r; pc_ready = rdy;
        flush_valid = fv; flush_pc = fpc;
        jump_valid = jv; jump_dest = jd;
        br_valid = bv; br_pc = bpc; br_offset = boff;
    endtask

    task automatic step_check(input string tag, input logic [31:0] e_pc,
                              input logic [1:0] e_ep, input logic e_val,
                              input logic e_pred);
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".epoch"}, {30'd0, pc_epoch}, {30'd0, e_ep});
        chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, e_val});
        chk({tag, ".pred"}, {31'd0, pc_pred_taken}, {31'd0, e_pred});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //          rst rdy fv fpc      jv jd           bv bpc      boff          e_pc          ep val pred
        vt.push_back(mk(1, 0, 0, 0,       0, 0,           0, 0,       0,            32'h1000,     0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h1000,     0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h1004,     0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h1008,     0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0,       0, 0,           0, 0,       0,            32'h1008,     0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0,       0, 0,           0, 0,       0,            32'h1008,     0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0,       0, 0,           0, 0,       0,            32'h1008,     0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h100C,     0, 1, 0));
        vt.push_back(mk(0, 1, 1, 32'h80,  1, 32'h200,     1, 32'h10,  32'h4,        32'h80,       1, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h80,       1, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h84,       1, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           1, 32'h2000, 32'hFFFFFFF0, 32'h1FF0,    2, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h1FF0,     2, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       1, 32'hFFFFFFFC, 0, 0,      0,            32'hFFFFFFFC, 3, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'hFFFFFFFC, 3, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h0,        3, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       1, 32'h500,     0, 0,       0,            32'h500,      0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       1, 32'h600,     0, 0,       0,            32'h600,      1, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h600,      1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0,       0, 0,           0, 0,       0,            32'h600,      1, 1, 0));
        vt.push_back(mk(1, 0, 0, 0,       1, 32'h900,     0, 0,       0,            32'h1000,     0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h1000,     0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0,       1, 32'h700,     0, 0,       0,            32'h700,      1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,       0, 0,           0, 0,       0,            32'h700,      1, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h704,      1, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       1, 32'h900,     1, 32'h2000, 32'h8,       32'h900,      2, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h900,      2, 1, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           1, 32'h10,  32'h20,       32'h30,       3, 0, 0));
        vt.push_back(mk(0, 1, 0, 0,       0, 0,           0, 0,       0,            32'h30,       3, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].rdy, vt[i].fv, vt[i].fpc, vt[i].jv,
                  vt[i].jd, vt[i].bv, vt[i].bpc, vt[i].boff);
            step_check($sformatf("v%0d", i), vt[i].e_pc, vt[i].e_ep,
                       vt[i].e_val, vt[i].e_pred);
        end

`ifdef PC_BTB_EN
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check("btb.rst", 32'h1000, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 32'h40, 0, 0, 0);
        step_check("btb.j40", 32'h40, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step_check("btb.run40", 32'h40, 1, 1, 0);
        drive(0, 1, 0, 0, 1, 32'h300, 0, 0, 0);
        step_check("btb.j300", 32'h300, 2, 0, 0);
        drive(0, 1, 0, 0, 1, 32'h40, 0, 0, 0);
        step_check("btb.back40", 32'h40, 3, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step_check("btb.run40b", 32'h40, 3, 1, 0);
        step_check("btb.pred", 32'h300, 3, 1, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check("btb.rst2", 32'h1000, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 32'h40, 0, 0, 0);
        step_check("btb.j40b", 32'h40, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step_check("btb.run40c", 32'h40, 1, 1, 0);
        step_check("btb.seq", 32'h44, 1, 1, 0);
`else
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step_check($sformatf("seq%0d", i), 32'h34 + 32'(4 * i), 3, 1, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
